aes_enc_iter: RTL and testbench

Iterative AES-128 encryption core that consumes the combinational round-key generator. It latches a plaintext block and cipher key through a valid/ready handshake, and holds the key on `key_out` for the generator. It steps `round_idx` 0..10 and reads the returned `round_key` each cycle. It applies one AES round per clock and presents the ciphertext through a second valid/ready handshake.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/SBox.sv | 25 ++
 rtl/aes_mix_column.sv | 21 ++
 rtl/aes_mix_columns.sv | 14 +
 rtl/aes_enc_iter.sv | 95 +++++++++
 tb/tb_aes_enc_iter.sv | 275 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 encryption core.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  localparam int unsigned NR = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // State is column-major: byte (row r, column c) sits at index 4*c+r, byte 0 in [127:120].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/SBox.sv
// Full-state AES SubBytes: sixteen parallel lookups into the forward S-box.
module SBox (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      dout[127 - 8*i -: 8] = SBOX_TABLE[2047 - 8*din[127 - 8*i -: 8] -: 8];
    end
  end

endmodule

// File: rtl/aes_mix_column.sv
// MixColumns transform of a single 32-bit state column, row 0 in [31:24].
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                  a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                  a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                  gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};

endmodule

// File: rtl/aes_mix_columns.sv
// Combinational MixColumns over the whole 128-bit state, one instance per column.
module aes_mix_columns (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_mix_column u_col (
      .col_i(state_i[127 - 32*c -: 32]),
      .col_o(state_o[127 - 32*c -: 32])
    );
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption: one round per clock, round keys from an external generator.
module aes_enc_iter #(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic [127:0] key_out,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_state_e   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;

  logic [127:0] sub_bytes, shifted, mixed;

  SBox u_sbox (
    .din (st_q),
    .dout(sub_bytes)
  );

  assign shifted = shift_rows(sub_bytes);

  aes_mix_columns u_mix (
    .state_i(shifted),
    .state_o(mixed)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          st_d    = in_data;
          key_d   = in_key;
          round_d = '0;
        end
      end
      ST_RUN: begin
        round_d = round_q + 4'd1;
        if (round_q == '0) begin
          st_d = st_q ^ round_key;
        end else if (round_q == LAST_ROUND) begin
          st_d    = shifted ^ round_key;
          state_d = ST_DONE;
          round_d = '0;
        end else begin
          st_d = mixed ^ round_key;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = st_q;
  assign key_out   = key_q;
  assign round_idx = round_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: byte-array AES reference with an attached round-key generator model.
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, in_key, key_out, round_key, out_data;
  logic [3:0]   round_idx;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  aes_enc_iter #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_key   (in_key),
    .key_out  (key_out),
    .round_idx(round_idx),
    .round_key(round_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived mathematically: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r, q;
    logic [7:0] e;
    e = 8'hfe;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    q = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return q;
  endfunction

  function automatic logic [127:0] keygen(input logic [127:0] key, input logic [3:0] idx);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          k;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    if (idx > 4'd10) return '0;
    k = 4 * int'(idx);
    return {w[k], w[k+1], w[k+2], w[k+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk, res;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
    rk = keygen(key, 4'd0);
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_f(s[i]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c + row] = s[4*((c + row) % 4) + row];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end
      rk = keygen(key, 4'(r));
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  assign round_key = keygen(key_out, round_idx);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in_ready"},  in_ready,  1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"},  out_data,  0);
    chk({tag, " key_out"},   key_out,   0);
    chk({tag, " round_idx"}, round_idx, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, " ready wait"}, in_ready, 1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int hold);
    wait_ready(tag);
    in_valid = 1'b1; in_data = pt; in_key = key;
    step();
    in_valid = 1'b0;
    chk({tag, " busy"}, in_ready, 0);
    chk({tag, " key_out"}, key_out, key);
    for (int k = 0; k <= 10; k++) begin
      chk({tag, " round_idx"}, round_idx, 128'(k));
      chk({tag, " early valid"}, out_valid, 0);
      step();
    end
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " out_data"}, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, " held data"}, out_data, exp);
      chk({tag, " held valid"}, out_valid, 1);
      chk({tag, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " idle in_ready"}, in_ready, 1);
    chk({tag, " idle out_valid"}, out_valid, 0);
  endtask

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pa, ka, pb, kb, ea, eb, got1;
    int n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;

    run_block("appB", B_PT, B_KEY, B_CT, 0);
    run_block("appC", C_PT, C_KEY, C_CT, 0);

    pa = {$urandom, $urandom, $urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    run_block("backpressure", pa, ka, aes_ref(pa, ka), 20);

    // New data offered and out_ready high while busy must not disturb the block.
    pa = {$urandom, $urandom, $urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    ea = aes_ref(pa, ka);
    wait_ready("busy");
    in_valid = 1'b1; in_data = pa; in_key = ka;
    step();
    in_data = pb; in_key = kb; out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      chk("busy key_out", key_out, ka);
      chk("busy valid", out_valid, 0);
      if (k == 10) in_valid = 1'b0;
      step();
    end
    chk("busy out_valid", out_valid, 1);
    chk("busy out_data", out_data, ea);
    step();
    out_ready = 1'b0;
    chk("busy idle", in_ready, 1);

    wait_ready("abort");
    in_valid = 1'b1; in_data = C_PT; in_key = C_KEY;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("abort round", round_idx, 5);
    rst = 1'b1; in_valid = 1'b1; in_data = B_PT; in_key = B_KEY;
    step();
    chk_reset("abort");
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("abort no valid", out_valid, 0);
      chk("abort idle", in_ready, 1);
      step();
    end
    run_block("after abort", B_PT, B_KEY, B_CT, 0);

    pa = {$urandom, $urandom, $urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    ea = aes_ref(pa, ka);
    eb = aes_ref(pb, kb);
    got1 = '0;
    wait_ready("b2b");
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = pa; in_key = ka;
    step();
    in_data = pb; in_key = kb;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      if (out_valid === 1'b1) got1 = out_data;
      step();
      n++;
    end
    chk("b2b ready gap", 128'(n), 12);
    chk("b2b first ct", got1, ea);
    step();
    in_valid = 1'b0;
    chk("b2b second key", key_out, kb);
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("b2b latency", 128'(n), 11);
    chk("b2b second ct", out_data, eb);
    step();
    out_ready = 1'b0;

    for (int r = 0; r < 4; r++) begin
      pa = {$urandom, $urandom, $urandom, $urandom};
      ka = {$urandom, $urandom, $urandom, $urandom};
      run_block("random", pa, ka, aes_ref(pa, ka), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
